config_chain_loader: RTL and testbench

- Drives the serial configuration chain of a CGRA tile from its head end. The chain is a series of ConfigCell and const stages linked ConfigIn→ConfigOut.
- Takes 32-bit configuration words over a valid/ready stream and shifts exactly CHAIN_LEN bits into the chain, one bit per enabled cycle.
- At the same time it captures the bits leaving the chain tail, so the previous configuration can be read back and checked.
- Sits between the host/CSR configuration port and each tile's config chain.

---
 rtl/config_chain_loader.sv | 107 ++++++++++
 tb/tb_config_chain_loader.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/config_chain_loader.sv
// Head-end loader for a tile's serial configuration chain: streams WORD_W-bit words in LSB-first
// while capturing the bits that fall out of the chain tail for readback.
module config_chain_loader #(
   parameter int CHAIN_LEN = 46,
   parameter int WORD_W    = 32
) (
   input  logic              Config_Clock,
   input  logic              Config_Reset,
   input  logic              start,
   input  logic              abort,
   input  logic [WORD_W-1:0] word_in,
   input  logic              word_valid,
   output logic              word_ready,
   output logic              ConfigOut,
   output logic              shift_en,
   input  logic              ConfigIn,
   output logic [WORD_W-1:0] rb_word,
   output logic              rb_valid,
   output logic              busy,
   output logic              done,
   output logic              aborted
);
   localparam int NWORDS = (CHAIN_LEN + WORD_W - 1) / WORD_W;
   localparam int LAST   = CHAIN_LEN - (NWORDS - 1) * WORD_W;
   localparam int BW     = $clog2(WORD_W + 1);
   localparam int NW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_SHIFT, S_DONE} state_t;

   state_t            state;
   logic [WORD_W-1:0] sreg, shadow, shadow_nxt, mask;
   logic [BW-1:0]     bit_cnt, wbits;
   logic [NW-1:0]     word_cnt;
   logic              last_word;

   assign last_word  = (word_cnt == NW'(NWORDS - 1));
   // abort wins over a coincident handshake or shift, so the chain never moves on that edge
   assign word_ready = (state == S_FETCH) && !abort;
   assign shift_en   = (state == S_SHIFT) && !abort;
   assign ConfigOut  = (state == S_SHIFT) ? sreg[0] : 1'b0;
   assign busy       = (state != S_IDLE);

   always_comb begin
      shadow_nxt = shadow;
      mask       = '0;
      for (int i = 0; i < WORD_W; i++) begin
         if (BW'(i) == bit_cnt) shadow_nxt[i] = ConfigIn;
         mask[i] = (BW'(i) < wbits);
      end
   end

   always_ff @(posedge Config_Clock or negedge Config_Reset) begin
      if (!Config_Reset) begin
         state    <= S_IDLE;
         sreg     <= '0;
         shadow   <= '0;
         bit_cnt  <= '0;
         wbits    <= '0;
         word_cnt <= '0;
         rb_word  <= '0;
         rb_valid <= 1'b0;
         done     <= 1'b0;
         aborted  <= 1'b0;
      end else begin
         rb_valid <= 1'b0;
         done     <= 1'b0;
         aborted  <= 1'b0;
         if (abort && state != S_IDLE) begin
            state    <= S_IDLE;
            aborted  <= 1'b1;
            bit_cnt  <= '0;
            word_cnt <= '0;
         end else begin
            case (state)
               S_IDLE: if (start) begin
                  state    <= S_FETCH;
                  word_cnt <= '0;
               end
               S_FETCH: if (word_valid) begin
                  sreg    <= word_in;
                  wbits   <= last_word ? BW'(LAST) : BW'(WORD_W);
                  bit_cnt <= '0;
                  shadow  <= '0;
                  state   <= S_SHIFT;
               end
               S_SHIFT: begin
                  sreg    <= sreg >> 1;
                  shadow  <= shadow_nxt;
                  bit_cnt <= bit_cnt + 1'b1;
                  if (bit_cnt == wbits - 1'b1) begin
                     rb_word  <= shadow_nxt & mask;
                     rb_valid <= 1'b1;
                     if (last_word) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                     end else begin
                        word_cnt <= word_cnt + 1'b1;
                        state    <= S_FETCH;
                     end
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_config_chain_loader.sv
// Directed bench for config_chain_loader with a 46-bit loopback chain model on the serial port.
module tb_config_chain_loader;
   localparam int CL = 46;
   localparam int WW = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0, abort = 1'b0, word_valid = 1'b0;
   logic [WW-1:0] word_in = '0;
   logic          word_ready, cfg_out, shift_en, cfg_in, rb_valid, busy, done, aborted;
   logic [WW-1:0] rb_word;

   logic [CL-1:0] chain = '0, pval = '0;
   logic          preload = 1'b0;
   logic [WW-1:0] words [2];

   int errors = 0, checks = 0;

   // run results
   int done_cyc, busy_low, ab_cyc, nshift, rb_cnt, rb_cyc0, rb_cyc1, widx;
   logic [WW-1:0] rb0, rb1;
   logic [63:0]   stream;
   logic          gap_ok, ab_ready;

   config_chain_loader #(.CHAIN_LEN(CL), .WORD_W(WW)) dut (
      .Config_Clock(clk), .Config_Reset(rst_n), .start(start), .abort(abort),
      .word_in(word_in), .word_valid(word_valid), .word_ready(word_ready),
      .ConfigOut(cfg_out), .shift_en(shift_en), .ConfigIn(cfg_in),
      .rb_word(rb_word), .rb_valid(rb_valid), .busy(busy), .done(done), .aborted(aborted)
   );

   always #5 clk = ~clk;

   // chain tail is bit 0; new bits enter at the head (bit CL-1)
   assign cfg_in = chain[0];
   always @(posedge clk)
      if (preload) chain <= pval;
      else if (shift_en) chain <= {cfg_out, chain[CL-1:1]};

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic load_chain(input logic [CL-1:0] v);
      pval = v; preload = 1'b1;
      @(posedge clk); #1;
      preload = 1'b0;
   endtask

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_outs"}, {word_ready, cfg_out, shift_en, rb_valid, busy, done, aborted}, 7'b0);
      chk({tag, "_rb"}, rb_word, 0);
   endtask

   // c0 is the start cycle; inputs are driven 1 time unit after each edge, outputs sampled 1 later
   task automatic run_load(input int gap, input int abort_at, input int start_at, input int max_cyc);
      logic hs;
      done_cyc = -1; busy_low = -1; ab_cyc = -1; nshift = 0; rb_cnt = 0;
      rb_cyc0 = -1; rb_cyc1 = -1; rb0 = '0; rb1 = '0; stream = '0; widx = 0;
      gap_ok = 1'b1; ab_ready = 1'b1;
      for (int cyc = 0; cyc < max_cyc; cyc++) begin
         start      = (cyc == 0) || (cyc == start_at);
         abort      = (cyc == abort_at);
         word_valid = (widx < 2) && !(widx == 1 && cyc >= 34 && cyc < 34 + gap);
         word_in    = words[(widx < 2) ? widx : 1];
         #1;
         if (widx == 1 && cyc >= 34 && cyc < 34 + gap) gap_ok &= word_ready && !shift_en;
         if (shift_en && nshift < 64) begin stream[nshift] = cfg_out; nshift++; end
         if (rb_valid) begin
            if (rb_cnt == 0) begin rb0 = rb_word; rb_cyc0 = cyc; end
            else begin rb1 = rb_word; rb_cyc1 = cyc; end
            rb_cnt++;
         end
         if (done && done_cyc < 0) done_cyc = cyc;
         if (aborted && ab_cyc < 0) ab_cyc = cyc;
         if (cyc > 0 && !busy && busy_low < 0) busy_low = cyc;
         if (abort) ab_ready = word_ready;
         hs = word_valid && word_ready;
         @(posedge clk); #1;
         if (hs) widx++;
      end
      start = 1'b0; abort = 1'b0; word_valid = 1'b0;
   endtask

   localparam logic [CL-1:0] P = {14'h2A5B, 32'hDEADBEEF};

   initial begin
      logic [CL-1:0] pshift;
      words[0] = 32'h0000_00A5;
      words[1] = 32'h0000_1234;
      #3;
      check_idle_outputs("reset");
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // nominal load over a preloaded chain
      load_chain(P);
      run_load(0, -1, -1, 60);
      chk("n_shift", nshift, 46);
      chk("stream_w0", stream[31:0], 32'hA5);
      chk("stream_w1", stream[45:32], 14'h1234);
      chk("done_cyc", done_cyc, 49);
      chk("busy_low", busy_low, 50);
      chk("rb_cyc0", rb_cyc0, 34);
      chk("rb0", rb0, 32'hDEADBEEF);
      chk("rb_cyc1", rb_cyc1, 49);
      chk("rb1", rb1, 32'h0000_2A5B);
      chk("no_abort", ab_cyc, -1);

      // reload reads back the first load; stray start at c10 is ignored
      run_load(0, -1, 10, 60);
      chk("rl_rb0", rb0, 32'hA5);
      chk("rl_rb1", rb1, 32'h1234);
      chk("rl_done", done_cyc, 49);
      chk("rl_busy_low", busy_low, 50);
      chk("rl_rb_cnt", rb_cnt, 2);

      // 5-cycle word_valid gap before word 1
      run_load(5, -1, -1, 70);
      chk("gap_hold", gap_ok, 1);
      chk("gap_done", done_cyc, 54);
      chk("gap_n_shift", nshift, 46);
      chk("gap_stream", stream[45:0], {14'h1234, 32'hA5});
      chk("gap_rb1", rb1, 32'h1234);

      // abort at c20 of the first word: 18 bits already in the chain
      load_chain(P);
      run_load(0, 20, -1, 40);
      chk("ab_cyc", ab_cyc, 21);
      chk("ab_busy_low", busy_low, 21);
      chk("ab_no_done", done_cyc, -1);
      chk("ab_no_rb", rb_cnt, 0);
      chk("ab_n_shift", nshift, 18);
      pshift = P >> 18;
      chk("ab_chain_new", chain[45:28], 18'hA5);
      chk("ab_chain_old", chain[27:0], pshift[27:0]);

      // abort coincident with a word handshake plus start while busy
      run_load(0, 1, 1, 6);
      chk("abhs_ready", ab_ready, 0);
      chk("abhs_widx", widx, 0);
      chk("abhs_cyc", ab_cyc, 2);
      chk("abhs_n_shift", nshift, 0);
      chk("abhs_idle", busy, 0);

      // reset in the middle of shifting, then a fresh full load
      run_load(0, -1, -1, 15);
      rst_n = 1'b0;
      #1;
      check_idle_outputs("midrst");
      @(posedge clk); #1;
      @(posedge clk); #1;
      check_idle_outputs("midrst_hold");
      rst_n = 1'b1;
      @(posedge clk); #1;
      load_chain(P);
      run_load(0, -1, -1, 60);
      chk("rst_rb0", rb0, 32'hDEADBEEF);
      chk("rst_rb1", rb1, 32'h2A5B);
      chk("rst_done", done_cyc, 49);
      chk("rst_n_shift", nshift, 46);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
